// File: rtl/mem_dbus_master_pkg.sv
// Shared definitions for the MEM-stage data-bus initiator: aluop codes,
// stall polarity constants and FSM/access-size encodings.
package mem_dbus_master_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_BUSY       = 2'b01,
        ST_WAIT_STALL = 2'b10
    } dbus_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } acc_size_e;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering for one load/store: byte selects, replicated
// store data, load extension and alignment checks. Purely combinational.
module mem_lane_align
    import mem_dbus_master_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_data_i,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic [3:0]  sel_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_load_o,
    output logic        misalign_store_o
);

    acc_size_e   size;
    logic        sext;
    logic        misalign;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        sext       = 1'b0;
        size       = SZ_NONE;
        case (op_i)
            EXE_LB_OP:  begin is_load_o  = 1'b1; sext = 1'b1; size = SZ_BYTE; end
            EXE_LBU_OP: begin is_load_o  = 1'b1;              size = SZ_BYTE; end
            EXE_LH_OP:  begin is_load_o  = 1'b1; sext = 1'b1; size = SZ_HALF; end
            EXE_LHU_OP: begin is_load_o  = 1'b1;              size = SZ_HALF; end
            EXE_LW_OP:  begin is_load_o  = 1'b1;              size = SZ_WORD; end
            EXE_SB_OP:  begin is_store_o = 1'b1;              size = SZ_BYTE; end
            EXE_SH_OP:  begin is_store_o = 1'b1;              size = SZ_HALF; end
            EXE_SW_OP:  begin is_store_o = 1'b1;              size = SZ_WORD; end
            default:    ;
        endcase
    end

    // Lane 0 is the most significant byte (big-endian).
    always_comb begin
        byte_v = 8'h00;
        case (addr_lo_i)
            2'b00:   byte_v = rd_data_i[31:24];
            2'b01:   byte_v = rd_data_i[23:16];
            2'b10:   byte_v = rd_data_i[15:8];
            default: byte_v = rd_data_i[7:0];
        endcase
        half_v = addr_lo_i[1] ? rd_data_i[15:0] : rd_data_i[31:16];
    end

    always_comb begin
        sel_o     = 4'b0000;
        st_data_o = ZERO_WORD;
        ld_data_o = ZERO_WORD;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                sel_o     = 4'b1000 >> addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
                ld_data_o = sext ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
            end
            SZ_HALF: begin
                misalign  = addr_lo_i[0];
                sel_o     = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                st_data_o = {2{st_data_i[15:0]}};
                ld_data_o = sext ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
            end
            SZ_WORD: begin
                misalign  = (addr_lo_i != 2'b00);
                sel_o     = 4'b1111;
                st_data_o = st_data_i;
                ld_data_o = rd_data_i;
            end
            default: ;
        endcase
        if (!is_load_o) ld_data_o = ZERO_WORD;
        if (!is_store_o) st_data_o = ZERO_WORD;
    end

    assign misalign_load_o  = misalign & is_load_o;
    assign misalign_store_o = misalign & is_store_o;

endmodule

// File: rtl/mem_dbus_master.sv
// MEM-stage Wishbone-classic initiator: one single access per load/store,
// stalling the pipeline until ack and parking the result while MEM/WB is frozen.
//
// state         | meaning
// ST_IDLE       | no access; a valid request launches the bus cycle
// ST_BUSY       | cyc/stb asserted, waiting for ack
// ST_WAIT_STALL | access done, result held in rd_buf until MEM/WB unfreezes
module mem_dbus_master
    import mem_dbus_master_pkg::*;
#(
    parameter int MEM_STALL_IDX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        stallreq,
    output logic [31:0] load_data,
    output logic        misalign_load,
    output logic        misalign_store
);

    dbus_state_e state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rd_buf_q, rd_buf_d;

    logic        is_load, is_store;
    logic [3:0]  lane_sel;
    logic [31:0] lane_st_data;
    logic [31:0] lane_ld_data;
    logic        req;
    logic        mem_stall;

    mem_lane_align u_lane (
        .op_i             (mem_aluop),
        .addr_lo_i        (mem_mem_addr[1:0]),
        .st_data_i        (mem_reg2),
        .rd_data_i        (wb_dat_i),
        .is_load_o        (is_load),
        .is_store_o       (is_store),
        .sel_o            (lane_sel),
        .st_data_o        (lane_st_data),
        .ld_data_o        (lane_ld_data),
        .misalign_load_o  (misalign_load),
        .misalign_store_o (misalign_store)
    );

    assign req       = (is_load | is_store) & ~(misalign_load | misalign_store) & ~flush;
    assign mem_stall = stall[MEM_STALL_IDX];

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        rd_buf_d = rd_buf_q;
        stallreq = 1'b0;

        if (flush) begin
            // Flush beats a same-cycle ack; rd_buf is deliberately left alone.
            state_d = ST_IDLE;
            adr_d   = ZERO_WORD;
            dat_d   = ZERO_WORD;
            sel_d   = 4'b0000;
            we_d    = 1'b0;
            cyc_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    adr_d = ZERO_WORD;
                    dat_d = ZERO_WORD;
                    sel_d = 4'b0000;
                    we_d  = 1'b0;
                    cyc_d = 1'b0;
                    if (req) begin
                        adr_d    = {mem_mem_addr[31:2], 2'b00};
                        dat_d    = lane_st_data;
                        sel_d    = lane_sel;
                        we_d     = is_store;
                        cyc_d    = 1'b1;
                        stallreq = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (wb_ack_i) begin
                        adr_d    = ZERO_WORD;
                        dat_d    = ZERO_WORD;
                        sel_d    = 4'b0000;
                        we_d     = 1'b0;
                        cyc_d    = 1'b0;
                        rd_buf_d = lane_ld_data;
                        state_d  = (mem_stall == STOP) ? ST_WAIT_STALL : ST_IDLE;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                ST_WAIT_STALL: begin
                    if (mem_stall == NO_STOP) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign load_data = (state_q == ST_WAIT_STALL) ? rd_buf_q : lane_ld_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            adr_q    <= ZERO_WORD;
            dat_q    <= ZERO_WORD;
            sel_q    <= 4'b0000;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_mem_dbus_master.sv
// Directed bench for mem_dbus_master: loads, stores, wait states, misalignment,
// MEM/WB stall hold, flush and mid-access reset.
module tb_mem_dbus_master;
    import mem_dbus_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        stallreq;
    logic [31:0] load_data;
    logic        misalign_load;
    logic        misalign_store;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_dbus_master #(.MEM_STALL_IDX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .mem_aluop      (mem_aluop),
        .mem_mem_addr   (mem_mem_addr),
        .mem_reg2       (mem_reg2),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_we_o        (wb_we_o),
        .wb_sel_o       (wb_sel_o),
        .wb_stb_o       (wb_stb_o),
        .wb_cyc_o       (wb_cyc_o),
        .stallreq       (stallreq),
        .load_data      (load_data),
        .misalign_load  (misalign_load),
        .misalign_store (misalign_store)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 6'h00; flush = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        set_op(EXE_NOP_OP, 32'h0, 32'h0);
        #2;
        total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=0000000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
        total++; if ({wb_adr_o, wb_dat_o} !== 64'h0) begin bad++; $display("FAIL reset_adr_dat got=%h/%h exp=0/0", wb_adr_o, wb_dat_o); end
        total++; if ({stallreq, misalign_load, misalign_store, load_data} !== 35'h0) begin bad++; $display("FAIL reset_comb got sr=%b ml=%b ms=%b ld=%h exp 0", stallreq, misalign_load, misalign_store, load_data); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        int sr_cnt;
        set_op(EXE_LW_OP, 32'h0000_1004, 32'h0);
        #1;
        sr_cnt = stallreq;
        total++; if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL lw_req_cyc got=%b exp=0", wb_cyc_o); end
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        #1;
        sr_cnt += stallreq;
        total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b1101111) begin bad++; $display("FAIL lw_bus_ctl got=%b exp=1101111", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
        total++; if (wb_adr_o !== 32'h0000_1004) begin bad++; $display("FAIL lw_adr got=%h exp=00001004", wb_adr_o); end
        total++; if (load_data !== 32'h1234_5678) begin bad++; $display("FAIL lw_load_data got=%h exp=12345678", load_data); end
        total++; if (sr_cnt !== 1) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=1", sr_cnt); end
        tick();
        set_op(EXE_NOP_OP, 32'h0, 32'h0); wb_ack_i = 1'b0;
        #1;
        total++; if ({wb_cyc_o, wb_stb_o, wb_sel_o, stallreq} !== 7'b0) begin bad++; $display("FAIL lw_idle got=%b exp=0000000", {wb_cyc_o, wb_stb_o, wb_sel_o, stallreq}); end
    endtask

    task automatic test_load(input string nm, input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] rdat, input logic [3:0] exp_sel, input logic [31:0] exp_ld);
        tick();
        set_op(op, addr, 32'h0);
        #1;
        total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL %s_stallreq got=%b exp=1", nm, stallreq); end
        tick();
        wb_ack_i = 1'b1; wb_dat_i = rdat;
        #1;
        total++; if ({wb_cyc_o, wb_we_o, wb_sel_o} !== {2'b10, exp_sel}) begin bad++; $display("FAIL %s_sel got=%b exp=%b", nm, {wb_cyc_o, wb_we_o, wb_sel_o}, {2'b10, exp_sel}); end
        total++; if (wb_adr_o !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL %s_adr got=%h exp=%h", nm, wb_adr_o, {addr[31:2], 2'b00}); end
        total++; if (load_data !== exp_ld) begin bad++; $display("FAIL %s_load_data got=%h exp=%h", nm, load_data, exp_ld); end
        tick();
        set_op(EXE_NOP_OP, 32'h0, 32'h0); wb_ack_i = 1'b0;
    endtask

    task automatic test_sh_waits();
        int sr_cnt;
        tick();
        set_op(EXE_SH_OP, 32'h0000_2002, 32'hAAAA_BEEF);
        #1;
        sr_cnt = stallreq;
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL sh_load_data got=%h exp=0", load_data); end
        for (int i = 0; i < 4; i++) begin
            tick();
            wb_ack_i = (i == 3);
            #1;
            total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b1110011) begin bad++; $display("FAIL sh_ctl_%0d got=%b exp=1110011", i, {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
            total++; if ({wb_adr_o, wb_dat_o} !== {32'h0000_2000, 32'hBEEF_BEEF}) begin bad++; $display("FAIL sh_adr_dat_%0d got=%h/%h exp=00002000/beefbeef", i, wb_adr_o, wb_dat_o); end
            if (i < 3) sr_cnt += stallreq;
            else begin
                total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL sh_ack_stallreq got=%b exp=0", stallreq); end
            end
        end
        total++; if (sr_cnt !== 4) begin bad++; $display("FAIL sh_stall_cycles got=%0d exp=4", sr_cnt); end
        tick();
        set_op(EXE_NOP_OP, 32'h0, 32'h0); wb_ack_i = 1'b0;
        #1;
        total++; if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o} !== 38'h0) begin bad++; $display("FAIL sh_release got cyc=%b we=%b sel=%b dat=%h exp 0", wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o); end
    endtask

    task automatic test_misalign();
        tick();
        set_op(EXE_LH_OP, 32'h0000_3001, 32'h0);
        #1;
        total++; if ({misalign_load, misalign_store, stallreq} !== 3'b100) begin bad++; $display("FAIL lh_mis got=%b exp=100", {misalign_load, misalign_store, stallreq}); end
        tick();
        total++; if ({wb_cyc_o, wb_stb_o, stallreq} !== 3'b000) begin bad++; $display("FAIL lh_mis_nobus got=%b exp=000", {wb_cyc_o, wb_stb_o, stallreq}); end
        set_op(EXE_SW_OP, 32'h0000_3002, 32'h1234_5678);
        #1;
        total++; if ({misalign_load, misalign_store, stallreq} !== 3'b010) begin bad++; $display("FAIL sw_mis got=%b exp=010", {misalign_load, misalign_store, stallreq}); end
        tick();
        total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, stallreq} !== 4'b0000) begin bad++; $display("FAIL sw_mis_nobus got=%b exp=0000", {wb_cyc_o, wb_stb_o, wb_we_o, stallreq}); end
        set_op(EXE_NOP_OP, 32'h0, 32'h0);
    endtask

    task automatic test_wait_stall();
        tick();
        set_op(EXE_LW_OP, 32'h0000_4000, 32'h0);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; stall = 6'b011111;
        #1;
        total++; if ({stallreq, load_data} !== {1'b0, 32'hCAFE_F00D}) begin bad++; $display("FAIL ws_ack got sr=%b ld=%h exp 0/cafef00d", stallreq, load_data); end
        for (int i = 0; i < 2; i++) begin
            tick();
            wb_ack_i = (i == 0); wb_dat_i = 32'hDEAD_BEEF;
            #1;
            total++; if (load_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL ws_hold_%0d got=%h exp=cafef00d", i, load_data); end
            total++; if ({wb_cyc_o, stallreq} !== 2'b00) begin bad++; $display("FAIL ws_quiet_%0d got=%b exp=00", i, {wb_cyc_o, stallreq}); end
        end
        tick();
        wb_ack_i = 1'b0; stall = 6'b000000;
        #1;
        total++; if (load_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL ws_release got=%h exp=cafef00d", load_data); end
        tick();
        set_op(EXE_NOP_OP, 32'h0, 32'h0);
        #1;
        total++; if ({wb_cyc_o, stallreq, load_data} !== 34'h0) begin bad++; $display("FAIL ws_idle got cyc=%b sr=%b ld=%h exp 0", wb_cyc_o, stallreq, load_data); end
    endtask

    task automatic test_flush();
        tick();
        set_op(EXE_LW_OP, 32'h0000_5000, 32'h0);
        tick();
        flush = 1'b1;
        #1;
        total++; if ({wb_cyc_o, stallreq} !== 2'b10) begin bad++; $display("FAIL fl_cycle got=%b exp=10", {wb_cyc_o, stallreq}); end
        tick();
        flush = 1'b0; set_op(EXE_NOP_OP, 32'h0, 32'h0); wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0099;
        #1;
        total++; if ({wb_cyc_o, wb_stb_o, wb_sel_o, stallreq} !== 7'b0) begin bad++; $display("FAIL fl_drop got=%b exp=0000000", {wb_cyc_o, wb_stb_o, wb_sel_o, stallreq}); end
        total++; if (wb_adr_o !== 32'h0) begin bad++; $display("FAIL fl_adr got=%h exp=0", wb_adr_o); end
        tick();
        wb_ack_i = 1'b0;
        #1;
        total++; if ({wb_cyc_o, stallreq} !== 2'b00) begin bad++; $display("FAIL fl_late_ack got=%b exp=00", {wb_cyc_o, stallreq}); end
    endtask

    task automatic test_reset_busy();
        tick();
        set_op(EXE_SW_OP, 32'h0000_6000, 32'h1122_3344);
        tick();
        #1;
        total++; if ({wb_cyc_o, wb_we_o, wb_dat_o} !== {2'b11, 32'h1122_3344}) begin bad++; $display("FAIL rb_busy got cyc=%b we=%b dat=%h exp 1/1/11223344", wb_cyc_o, wb_we_o, wb_dat_o); end
        rst = 1'b0; set_op(EXE_NOP_OP, 32'h0, 32'h0);
        #1;
        total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b0) begin bad++; $display("FAIL rb_ctl got=%b exp=0000000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
        total++; if ({wb_adr_o, wb_dat_o} !== 64'h0) begin bad++; $display("FAIL rb_adr_dat got=%h/%h exp=0/0", wb_adr_o, wb_dat_o); end
        total++; if ({stallreq, load_data} !== 33'h0) begin bad++; $display("FAIL rb_comb got sr=%b ld=%h exp 0", stallreq, load_data); end
        tick();
        rst = 1'b1;
        tick();
        total++; if ({wb_cyc_o, stallreq} !== 2'b00) begin bad++; $display("FAIL rb_after got=%b exp=00", {wb_cyc_o, stallreq}); end
    endtask

    task automatic test_back_to_back();
        tick();
        set_op(EXE_LW_OP, 32'h0000_7000, 32'h0);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_CAFE;
        #1;
        total++; if (load_data !== 32'h0BAD_CAFE) begin bad++; $display("FAIL b2b_lw got=%h exp=0badcafe", load_data); end
        tick();
        wb_ack_i = 1'b0; set_op(EXE_SB_OP, 32'h0000_7001, 32'h0000_005A);
        #1;
        total++; if ({wb_cyc_o, stallreq} !== 2'b01) begin bad++; $display("FAIL b2b_sb_req got=%b exp=01", {wb_cyc_o, stallreq}); end
        tick();
        wb_ack_i = 1'b1;
        #1;
        total++; if ({wb_cyc_o, wb_we_o, wb_sel_o} !== 6'b110100) begin bad++; $display("FAIL b2b_sb_ctl got=%b exp=110100", {wb_cyc_o, wb_we_o, wb_sel_o}); end
        total++; if ({wb_adr_o, wb_dat_o} !== {32'h0000_7000, 32'h5A5A_5A5A}) begin bad++; $display("FAIL b2b_sb_adr_dat got=%h/%h exp=00007000/5a5a5a5a", wb_adr_o, wb_dat_o); end
        total++; if ({stallreq, load_data} !== 33'h0) begin bad++; $display("FAIL b2b_sb_ack got sr=%b ld=%h exp 0", stallreq, load_data); end
        tick();
        wb_ack_i = 1'b0; set_op(EXE_NOP_OP, 32'h0, 32'h0);
        #1;
        total++; if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", wb_cyc_o); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load("lb",  EXE_LB_OP,  32'h0000_1003, 32'h0000_0080, 4'b0001, 32'hFFFF_FF80);
        test_load("lbu", EXE_LBU_OP, 32'h0000_1003, 32'h0000_0080, 4'b0001, 32'h0000_0080);
        test_load("lb1", EXE_LB_OP,  32'h0000_1001, 32'h11C3_3344, 4'b0100, 32'hFFFF_FFC3);
        test_load("lh",  EXE_LH_OP,  32'h0000_2000, 32'h8001_7777, 4'b1100, 32'hFFFF_8001);
        test_load("lhu", EXE_LHU_OP, 32'h0000_2002, 32'h1234_F00D, 4'b0011, 32'h0000_F00D);
        test_sh_waits();
        test_misalign();
        test_wait_stall();
        test_flush();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
